// File: rtl/ai_cu_layer_seq_pkg.sv
// Shared types and constants for the layer sequencer: descriptor field
// positions, layer type codes, error codes and FSM state encoding.
package ai_cu_pkg;

    typedef enum logic [3:0] {
        LT_CONV = 4'd0,
        LT_FC   = 4'd1,
        LT_POOL = 4'd2,
        LT_NOP  = 4'd3
    } layer_type_e;

    localparam int TYPE_LSB = 0;
    localparam int K_LSB    = 4;
    localparam int S_LSB    = 8;
    localparam int RELU_BIT = 12;
    localparam int POOL_BIT = 13;
    localparam int LAST_BIT = 14;
    localparam int FIELD_W  = 4;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DECODE  = 3'd1,
        ST_READ    = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_WRITE   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } state_e;

    function automatic logic is_legal_type(input logic [FIELD_W-1:0] t);
        case (t)
            LT_CONV, LT_FC, LT_POOL, LT_NOP: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ai_cu_layer_seq_fifo.sv
// Descriptor queue: DEPTH x WIDTH circular buffer with occupancy counter,
// show-ahead read port and a synchronous flush.
module ai_inst_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == {(AW+1){1'b0}});
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else if (i_flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ai_cu_layer_seq.sv
// Layer sequencer: queues 32-bit layer descriptors and walks each one through
// decode, read, compute and write phases with per-phase timeouts.
module ai_cu_layer_seq
    import ai_cu_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int K_WIDTH    = 4,
    parameter int S_WIDTH    = 4,
    parameter int TYPE_WIDTH = 4,
    parameter int DEPTH      = 4,
    parameter int TO_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_valid,
    input  logic [INST_WIDTH-1:0] inst_word_in,
    output logic                  inst_ready,
    input  logic                  abort,
    output logic                  mem_read_start,
    input  logic                  mem_read_done,
    output logic                  seq_start,
    input  logic                  seq_done,
    output logic                  mem_write_start,
    input  logic                  mem_write_done,
    output logic [K_WIDTH-1:0]    kernel_size,
    output logic [S_WIDTH-1:0]    stride,
    output logic                  relu_en,
    output logic                  pool_en,
    output logic [TYPE_WIDTH-1:0] layer_type,
    output logic                  busy,
    output logic                  layer_done,
    output logic                  net_done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [7:0]            layer_count
);
    localparam logic [TO_W-1:0] TO_ZERO = {TO_W{1'b0}};
    localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    // Last wait cycle: the counter would step onto all-ones here.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_e                r_state;
    logic [INST_WIDTH-1:0] r_desc;
    logic [TO_W-1:0]       r_to_cnt;
    logic                  r_mem_read_start;
    logic                  r_seq_start;
    logic                  r_mem_write_start;
    logic [K_WIDTH-1:0]    r_kernel_size;
    logic [S_WIDTH-1:0]    r_stride;
    logic                  r_relu_en;
    logic                  r_pool_en;
    logic [TYPE_WIDTH-1:0] r_layer_type;
    logic                  r_busy;
    logic                  r_layer_done;
    logic                  r_net_done;
    logic                  r_err;
    logic [1:0]            r_err_code;
    logic [7:0]            r_layer_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [INST_WIDTH-1:0] w_head;
    logic [FIELD_W-1:0]    w_type;
    logic                  w_pool_skip_write;
    logic                  w_unused_desc;

    assign w_push = inst_valid && !w_full && !abort;
    assign w_pop  = !abort && !w_empty &&
                    ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_type = r_desc[TYPE_LSB +: FIELD_W];
    assign w_pool_skip_write = (w_type == LT_POOL) && !r_desc[POOL_BIT];
    assign w_unused_desc = ^r_desc[INST_WIDTH-1:LAST_BIT+1];

    ai_inst_fifo #(
        .WIDTH (INST_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (abort),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (inst_word_in),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= ST_IDLE;
            r_desc            <= {INST_WIDTH{1'b0}};
            r_to_cnt          <= TO_ZERO;
            r_mem_read_start  <= 1'b0;
            r_seq_start       <= 1'b0;
            r_mem_write_start <= 1'b0;
            r_kernel_size     <= {K_WIDTH{1'b0}};
            r_stride          <= {S_WIDTH{1'b0}};
            r_relu_en         <= 1'b0;
            r_pool_en         <= 1'b0;
            r_layer_type      <= {TYPE_WIDTH{1'b0}};
            r_busy            <= 1'b0;
            r_layer_done      <= 1'b0;
            r_net_done        <= 1'b0;
            r_err             <= 1'b0;
            r_err_code        <= ERR_NONE;
            r_layer_count     <= 8'd0;
        end else begin
            r_mem_read_start  <= 1'b0;
            r_seq_start       <= 1'b0;
            r_mem_write_start <= 1'b0;
            r_layer_done      <= 1'b0;
            r_net_done        <= 1'b0;
            r_err             <= 1'b0;
            if (abort) begin
                r_state       <= ST_IDLE;
                r_busy        <= 1'b0;
                r_layer_count <= 8'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_empty) begin
                            r_state <= ST_DECODE;
                            r_busy  <= 1'b1;
                            r_desc  <= w_head;
                        end
                    end
                    ST_DECODE: begin
                        r_kernel_size <= r_desc[K_LSB +: K_WIDTH];
                        r_stride      <= r_desc[S_LSB +: S_WIDTH];
                        r_relu_en     <= r_desc[RELU_BIT];
                        r_pool_en     <= r_desc[POOL_BIT];
                        r_layer_type  <= r_desc[TYPE_LSB +: TYPE_WIDTH];
                        if (!is_legal_type(w_type)) begin
                            r_state    <= ST_ERR;
                            r_err      <= 1'b1;
                            r_err_code <= ERR_ILLEGAL;
                        end else if (w_type == LT_NOP) begin
                            r_state       <= ST_DONE;
                            r_layer_done  <= 1'b1;
                            r_net_done    <= r_desc[LAST_BIT];
                            r_layer_count <= r_layer_count + 8'd1;
                        end else begin
                            r_state          <= ST_READ;
                            r_mem_read_start <= 1'b1;
                            r_to_cnt         <= TO_ZERO;
                        end
                    end
                    ST_READ: begin
                        if (mem_read_done) begin
                            r_state     <= ST_COMPUTE;
                            r_seq_start <= 1'b1;
                            r_to_cnt    <= TO_ZERO;
                        end else if (r_to_cnt == TO_LAST) begin
                            r_state    <= ST_ERR;
                            r_err      <= 1'b1;
                            r_err_code <= ERR_TIMEOUT;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_ONE;
                        end
                    end
                    ST_COMPUTE: begin
                        if (seq_done && w_pool_skip_write) begin
                            r_state       <= ST_DONE;
                            r_layer_done  <= 1'b1;
                            r_net_done    <= r_desc[LAST_BIT];
                            r_layer_count <= r_layer_count + 8'd1;
                        end else if (seq_done) begin
                            r_state           <= ST_WRITE;
                            r_mem_write_start <= 1'b1;
                            r_to_cnt          <= TO_ZERO;
                        end else if (r_to_cnt == TO_LAST) begin
                            r_state    <= ST_ERR;
                            r_err      <= 1'b1;
                            r_err_code <= ERR_TIMEOUT;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_ONE;
                        end
                    end
                    ST_WRITE: begin
                        if (mem_write_done) begin
                            r_state       <= ST_DONE;
                            r_layer_done  <= 1'b1;
                            r_net_done    <= r_desc[LAST_BIT];
                            r_layer_count <= r_layer_count + 8'd1;
                        end else if (r_to_cnt == TO_LAST) begin
                            r_state    <= ST_ERR;
                            r_err      <= 1'b1;
                            r_err_code <= ERR_TIMEOUT;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_ONE;
                        end
                    end
                    ST_DONE, ST_ERR: begin
                        // The count is shown for one cycle before a net-ending clear.
                        if ((r_state == ST_DONE) && r_desc[LAST_BIT]) begin
                            r_layer_count <= 8'd0;
                        end
                        if (!w_empty) begin
                            r_state <= ST_DECODE;
                            r_desc  <= w_head;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign inst_ready      = !w_full;
    assign mem_read_start  = r_mem_read_start;
    assign seq_start       = r_seq_start;
    assign mem_write_start = r_mem_write_start;
    assign kernel_size     = r_kernel_size;
    assign stride          = r_stride;
    assign relu_en         = r_relu_en;
    assign pool_en         = r_pool_en;
    assign layer_type      = r_layer_type;
    assign busy            = r_busy;
    assign layer_done      = r_layer_done;
    assign net_done        = r_net_done;
    assign err             = r_err;
    assign err_code        = r_err_code;
    assign layer_count     = r_layer_count;

endmodule

// File: tb/tb_ai_cu_layer_seq.sv
// Directed bench for ai_cu_layer_seq (TO_W=4, DEPTH=4) with hand-computed expectations.
module tb_ai_cu_layer_seq;
    localparam int P_RD  = 0;
    localparam int P_SEQ = 1;
    localparam int P_WR  = 2;
    localparam int P_LD  = 3;
    localparam int P_NET = 4;
    localparam int P_ERR = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [31:0] inst_word_in;
    logic        inst_ready;
    logic        abort;
    logic        mem_read_start;
    logic        mem_read_done;
    logic        seq_start;
    logic        seq_done;
    logic        mem_write_start;
    logic        mem_write_done;
    logic [3:0]  kernel_size;
    logic [3:0]  stride;
    logic        relu_en;
    logic        pool_en;
    logic [3:0]  layer_type;
    logic        busy;
    logic        layer_done;
    logic        net_done;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  layer_count;

    int n_vec = 0;
    int n_miss = 0;
    int n_rd = 0;
    int n_seq = 0;
    int n_wr = 0;
    int n_ld = 0;

    ai_cu_layer_seq #(.TO_W(4), .DEPTH(4)) dut (
        .clk (clk), .rst (rst), .inst_valid (inst_valid), .inst_word_in (inst_word_in),
        .inst_ready (inst_ready), .abort (abort),
        .mem_read_start (mem_read_start), .mem_read_done (mem_read_done),
        .seq_start (seq_start), .seq_done (seq_done),
        .mem_write_start (mem_write_start), .mem_write_done (mem_write_done),
        .kernel_size (kernel_size), .stride (stride), .relu_en (relu_en),
        .pool_en (pool_en), .layer_type (layer_type), .busy (busy),
        .layer_done (layer_done), .net_done (net_done), .err (err),
        .err_code (err_code), .layer_count (layer_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_read_start)  n_rd  <= n_rd + 1;
        if (seq_start)       n_seq <= n_seq + 1;
        if (mem_write_start) n_wr  <= n_wr + 1;
        if (layer_done)      n_ld  <= n_ld + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            P_RD:    return mem_read_start;
            P_SEQ:   return seq_start;
            P_WR:    return mem_write_start;
            P_LD:    return layer_done;
            P_NET:   return net_done;
            P_ERR:   return err;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_pulse(input string tag, input int sel, input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!pick(sel) && cyc < max_cyc);
        check({tag, "_seen"}, 32'(pick(sel)), 32'd1);
    endtask

    task automatic give_done(input int sel, input int dly);
        repeat (dly) step();
        case (sel)
            P_RD:    mem_read_done = 1'b1;
            P_SEQ:   seq_done = 1'b1;
            default: mem_write_done = 1'b1;
        endcase
        step();
        mem_read_done = 1'b0;
        seq_done = 1'b0;
        mem_write_done = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        inst_valid = 1'b1;
        inst_word_in = d;
        step();
        inst_valid = 1'b0;
    endtask

    initial begin
        int c;
        int ld_cnt;
        int snap_a;
        int snap_b;
        logic busy_ok;

        rst = 1'b1; inst_valid = 1'b0; inst_word_in = 32'd0; abort = 1'b0;
        mem_read_done = 1'b0; seq_done = 1'b0; mem_write_done = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(inst_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(layer_count), 32'd0);
        check("rst_errcode", 32'(err_code), 32'd0);
        check("rst_ksize", 32'(kernel_size), 32'd0);
        check("rst_pulses", 32'({mem_read_start, seq_start, mem_write_start, layer_done, net_done, err}), 32'd0);
        rst = 1'b0;
        step();

        // CONV k=3 s=1 relu last, each done 2 cycles after its start
        push(32'h0000_5130);
        wait_pulse("t1_rd", P_RD, 6, c);
        check("t1_rd_lat", 32'(c), 32'd2);
        check("t1_ksize", 32'(kernel_size), 32'd3);
        check("t1_stride", 32'(stride), 32'd1);
        check("t1_relu", 32'(relu_en), 32'd1);
        check("t1_type", 32'(layer_type), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        give_done(P_RD, 2);
        check("t1_seq_start", 32'(seq_start), 32'd1);
        give_done(P_SEQ, 2);
        check("t1_wr_start", 32'(mem_write_start), 32'd1);
        give_done(P_WR, 2);
        check("t1_ld_net", 32'({layer_done, net_done}), 32'd3);
        check("t1_count1", 32'(layer_count), 32'd1);
        step();
        check("t1_count0", 32'(layer_count), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // Queue fill while layer A is parked in READ, 5th offered, then 5 NOP layers
        push(32'h0000_0010);
        wait_pulse("t2_rd", P_RD, 6, c);
        check("t2_rd_lat", 32'(c), 32'd2);
        inst_valid = 1'b1;
        inst_word_in = 32'h0000_0003; step();
        inst_word_in = 32'h0000_0003; step();
        inst_word_in = 32'h0000_0003; step();
        inst_word_in = 32'h0000_0003; step();
        check("t2_full", 32'(inst_ready), 32'd0);
        inst_word_in = 32'h0000_4003;
        step(); step();
        check("t2_full_hold", 32'(inst_ready), 32'd0);
        mem_read_done = 1'b1; step(); mem_read_done = 1'b0;
        check("t2_seq_start", 32'(seq_start), 32'd1);
        seq_done = 1'b1; step(); seq_done = 1'b0;
        check("t2_wr_start_same_cycle", 32'(mem_write_start), 32'd1);
        mem_write_done = 1'b1; step(); mem_write_done = 1'b0;
        check("t2_a_done", 32'(layer_done), 32'd1);
        check("t2_full_at_pop", 32'(inst_ready), 32'd0);
        check("t2_a_count", 32'(layer_count), 32'd1);
        step();
        check("t2_ready_after_pop", 32'(inst_ready), 32'd1);
        step();
        inst_valid = 1'b0;
        ld_cnt = int'(layer_done);
        busy_ok = busy;
        for (int i = 0; i < 8; i++) begin
            step();
            ld_cnt += int'(layer_done);
            busy_ok = busy_ok & busy;
        end
        check("t2_ld_pulses", 32'(ld_cnt), 32'd5);
        check("t2_no_idle", 32'(busy_ok), 32'd1);
        check("t2_net_done", 32'(net_done), 32'd1);
        check("t2_count6", 32'(layer_count), 32'd6);
        step();
        check("t2_count0", 32'(layer_count), 32'd0);
        check("t2_idle", 32'(busy), 32'd0);

        // Illegal type 0x9 followed by NOP last
        snap_a = n_rd + n_seq + n_wr;
        inst_valid = 1'b1;
        inst_word_in = 32'h0000_0009; step();
        inst_word_in = 32'h0000_4003; step();
        inst_valid = 1'b0;
        wait_pulse("t3_err", P_ERR, 4, c);
        check("t3_err_lat", 32'(c), 32'd1);
        check("t3_errcode", 32'(err_code), 32'd1);
        check("t3_count_err", 32'(layer_count), 32'd0);
        wait_pulse("t3_net", P_NET, 4, c);
        check("t3_net_lat", 32'(c), 32'd2);
        check("t3_count1", 32'(layer_count), 32'd1);
        step();
        check("t3_count0", 32'(layer_count), 32'd0);
        check("t3_no_starts", 32'(n_rd + n_seq + n_wr - snap_a), 32'd0);

        // Compute timeout with TO_W=4, then the queued NOP runs
        inst_valid = 1'b1;
        inst_word_in = 32'h0000_0010; step();
        inst_word_in = 32'h0000_4003; step();
        inst_valid = 1'b0;
        wait_pulse("t4_rd", P_RD, 4, c);
        check("t4_rd_lat", 32'(c), 32'd1);
        give_done(P_RD, 0);
        check("t4_seq_start", 32'(seq_start), 32'd1);
        wait_pulse("t4_err", P_ERR, 20, c);
        check("t4_timeout_lat", 32'(c), 32'd15);
        check("t4_errcode", 32'(err_code), 32'd2);
        wait_pulse("t4_net", P_NET, 4, c);
        check("t4_next_lat", 32'(c), 32'd2);
        check("t4_count1", 32'(layer_count), 32'd1);
        check("t4_errcode_held", 32'(err_code), 32'd2);
        step();

        // Abort during WRITE with two descriptors queued
        inst_valid = 1'b1;
        inst_word_in = 32'h0000_0003; step();
        inst_word_in = 32'h0000_0010; step();
        inst_word_in = 32'h0000_0003; step();
        inst_word_in = 32'h0000_0003; step();
        inst_valid = 1'b0;
        check("t5_count1", 32'(layer_count), 32'd1);
        wait_pulse("t5_rd", P_RD, 4, c);
        give_done(P_RD, 0);
        give_done(P_SEQ, 0);
        check("t5_in_write", 32'(mem_write_start), 32'd1);
        abort = 1'b1;
        inst_valid = 1'b1;
        inst_word_in = 32'h0000_0003;
        step();
        abort = 1'b0;
        inst_valid = 1'b0;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ready", 32'(inst_ready), 32'd1);
        check("t5_count0", 32'(layer_count), 32'd0);
        check("t5_cfg_kept", 32'(kernel_size), 32'd1);
        check("t5_no_pulse", 32'({mem_write_start, layer_done, net_done, err}), 32'd0);
        snap_a = n_wr;
        snap_b = n_ld;
        mem_write_done = 1'b1; step(); mem_write_done = 1'b0;
        step(); step();
        check("t5_stay_idle", 32'(busy), 32'd0);
        check("t5_late_done_ignored", 32'(n_ld - snap_b), 32'd0);
        check("t5_no_wr_start", 32'(n_wr - snap_a), 32'd0);

        // POOL without pool_en skips the write phase
        push(32'h0000_4022);
        wait_pulse("t6_rd", P_RD, 6, c);
        give_done(P_RD, 1);
        check("t6_seq_start", 32'(seq_start), 32'd1);
        snap_a = n_wr;
        give_done(P_SEQ, 1);
        check("t6_ld_next", 32'(layer_done), 32'd1);
        check("t6_net", 32'(net_done), 32'd1);
        check("t6_type", 32'(layer_type), 32'd2);
        step();
        check("t6_no_write", 32'(n_wr - snap_a), 32'd0);

        // Asynchronous reset in the middle of a layer
        push(32'h0000_0010);
        wait_pulse("t7_rd", P_RD, 6, c);
        #2;
        rst = 1'b1;
        #1;
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_rd_start", 32'(mem_read_start), 32'd0);
        check("t7_ksize", 32'(kernel_size), 32'd0);
        check("t7_ready", 32'(inst_ready), 32'd1);
        rst = 1'b0;
        step(); step(); step();
        check("t7_stay_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
